// File: rtl/ddr3_sched_pkg.sv
// Shared types and constants for the DDR3 port scheduler.
package ddr3_sched_pkg;

    typedef enum logic [3:0] {
        ST_INIT = 4'b0001,
        ST_ARB  = 4'b0010,
        ST_WR   = 4'b0100,
        ST_RD   = 4'b1000
    } state_t;

    localparam logic [2:0] CMD_WR = 3'd0;
    localparam logic [2:0] CMD_RD = 3'd1;

    localparam int unsigned ADDR_STEP_DEF = 8;

endpackage

// File: rtl/ddr3_port_sched_if.sv
// Requester and MIG user-interface signals for ddr3_port_sched.
interface ddr3_port_sched_if #(
    parameter int unsigned NPORT  = 4,
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned LEN_W  = 8
);
    logic                      init_calib_complete;
    logic                      app_rdy;
    logic                      app_wdf_rdy;
    logic                      app_rd_data_valid;
    logic [NPORT-1:0]          req;
    logic [NPORT-1:0]          req_rd;
    logic [NPORT*ADDR_W-1:0]   req_addr;
    logic [NPORT*LEN_W-1:0]    req_len;
    logic [NPORT-1:0]          grant;
    logic [NPORT-1:0]          done;
    logic [NPORT-1:0]          wr_pop;
    logic [NPORT-1:0]          rd_push;
    logic                      app_en;
    logic [2:0]                app_cmd;
    logic [ADDR_W-1:0]         app_addr;
    logic                      app_wdf_wren;
    logic                      app_wdf_end;
    logic                      busy;
    logic                      err_orphan;

    modport master (
        input  init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data_valid,
        input  req, req_rd, req_addr, req_len,
        output grant, done, wr_pop, rd_push,
        output app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, busy, err_orphan
    );

    modport slave (
        output init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data_valid,
        output req, req_rd, req_addr, req_len,
        input  grant, done, wr_pop, rd_push,
        input  app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, busy, err_orphan
    );
endinterface

// File: rtl/ddr3_tag_fifo.sv
// In-order read tag FIFO with show-ahead head; push when full and pop when empty are ignored.
module ddr3_tag_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/ddr3_port_sched.sv
// Round-robin burst scheduler sharing the MIG user interface between NPORT requesters.
module ddr3_port_sched
    import ddr3_sched_pkg::*;
#(
    parameter int unsigned NPORT     = 4,
    parameter int unsigned ADDR_W    = 28,
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned ADDR_STEP = ADDR_STEP_DEF,
    parameter int unsigned TAG_DEPTH = 16
) (
    input  logic                 ui_clk,
    input  logic                 rst_n,
    ddr3_port_sched_if.master    bus
);
    localparam int unsigned PW = (NPORT > 1) ? $clog2(NPORT) : 1;

    state_t              state, state_nx;
    logic [PW-1:0]       rr_ptr, port_q, win_idx, rr_idx;
    logic                win_found;
    logic [2:0]          cmd_q;
    logic [ADDR_W-1:0]   cur_addr;
    logic [LEN_W-1:0]    len_q, beat_cnt, len_sel;
    logic                fire_wr, fire_rd, fire, last_beat;
    logic                tag_full, tag_empty, err_orphan_q;
    logic [PW-1:0]       tag_head;
    logic [ADDR_W-1:0]   addr_arr [NPORT];
    logic [LEN_W-1:0]    len_arr  [NPORT];

    for (genvar g = 0; g < NPORT; g++) begin : g_slice
        assign addr_arr[g] = bus.req_addr[g*ADDR_W +: ADDR_W];
        assign len_arr[g]  = bus.req_len[g*LEN_W +: LEN_W];
    end

    // First requester at or after rr_ptr, wrapping modulo NPORT.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        rr_idx    = '0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            rr_idx = PW'((32'(rr_ptr) + i) % NPORT);
            if (!win_found && bus.req[rr_idx]) begin
                win_found = 1'b1;
                win_idx   = rr_idx;
            end
        end
    end

    assign len_sel   = len_arr[win_idx];
    assign fire_wr   = (state == ST_WR) & bus.app_rdy & bus.app_wdf_rdy;
    assign fire_rd   = (state == ST_RD) & bus.app_rdy & ~tag_full;
    assign fire      = fire_wr | fire_rd;
    assign last_beat = (beat_cnt == len_q - LEN_W'(1));

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) state <= ST_INIT;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_INIT: if (bus.init_calib_complete) state_nx = ST_ARB;
            ST_ARB:  if (win_found) state_nx = bus.req_rd[win_idx] ? ST_RD : ST_WR;
            ST_WR,
            ST_RD:   if (fire && last_beat) state_nx = ST_ARB;
            default: state_nx = ST_INIT;
        endcase
    end

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            port_q       <= '0;
            cmd_q        <= CMD_WR;
            cur_addr     <= '0;
            len_q        <= '0;
            beat_cnt     <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            if (state == ST_ARB && win_found) begin
                rr_ptr   <= PW'((32'(win_idx) + 1) % NPORT);
                port_q   <= win_idx;
                cmd_q    <= bus.req_rd[win_idx] ? CMD_RD : CMD_WR;
                cur_addr <= addr_arr[win_idx];
                len_q    <= (len_sel == '0) ? LEN_W'(1) : len_sel;
                beat_cnt <= '0;
            end else if (fire) begin
                cur_addr <= cur_addr + ADDR_W'(ADDR_STEP);
                beat_cnt <= beat_cnt + LEN_W'(1);
            end
            if (bus.app_rd_data_valid && tag_empty) err_orphan_q <= 1'b1;
        end
    end

    ddr3_tag_fifo #(
        .WIDTH (PW),
        .DEPTH (TAG_DEPTH)
    ) u_tags (
        .clk   (ui_clk),
        .rst_n (rst_n),
        .push  (fire_rd),
        .pop   (bus.app_rd_data_valid),
        .din   (port_q),
        .head  (tag_head),
        .full  (tag_full),
        .empty (tag_empty)
    );

    // INIT counts as idle so every output reads 0 while reset is held.
    always_comb begin
        bus.app_en       = fire;
        bus.app_cmd      = cmd_q;
        bus.app_addr     = cur_addr;
        bus.app_wdf_wren = fire_wr;
        bus.app_wdf_end  = fire_wr;
        bus.wr_pop       = fire_wr ? (NPORT'(1) << port_q) : '0;
        bus.done         = (fire && last_beat) ? (NPORT'(1) << port_q) : '0;
        bus.grant        = (state == ST_ARB && win_found) ? (NPORT'(1) << win_idx) : '0;
        bus.rd_push      = (bus.app_rd_data_valid && !tag_empty) ? (NPORT'(1) << tag_head) : '0;
        bus.busy         = (state == ST_WR) || (state == ST_RD) || !tag_empty;
        bus.err_orphan   = err_orphan_q;
    end
endmodule
